// File: rtl/jt1943_arb_pkg.sv
// Shared types and helpers for the 1943 ROM arbiter.
// Contents:
//   arb_state_t : arbiter FSM states.
//   AW_DEF/DW_DEF : default address and data widths.
//   rr_pick()   : round-robin search over up to 8 pending slots.
package jt1943_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    localparam int AW_DEF = 22;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scans ptr+1, ptr+2, ... modulo slots and returns the first pending one.
    function automatic rr_pick_t rr_pick(input logic [7:0] pending,
                                         input logic [2:0] ptr,
                                         input int         slots);
        rr_pick_t   r;
        int         j;
        logic [2:0] j3;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= slots && !r.found) begin
                j  = (int'(ptr) + k) % slots;
                j3 = 3'(j);
                if (pending[j3]) begin
                    r.found = 1'b1;
                    r.idx   = j3;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jt1943_arb_slot.sv
// One requester's cache entry: cached address, valid flag, data word and
// the registered slot_ok.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : drop valid and slot_ok, keep data (download abort)
//   load            : capture addr_in as the address being fetched
//   fill, fill_data : store returned SDRAM word and mark valid
//   slot_req, addr_in : requester's level request and current address
//   hit, ok, data   : hit flag, registered ok, cached word
module jt1943_arb_slot
    import jt1943_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
    input  logic          slot_req,
    input  logic [AW-1:0] addr_in,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] data
);

    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          ok_q, ok_d;
    logic          addr_match;

    assign addr_match = (addr_q == addr_in);
    assign hit        = valid_q & addr_match;

    always_comb begin
        addr_d  = load ? addr_in : addr_q;
        data_d  = fill ? fill_data : data_q;
        valid_d = valid_q;
        if (load) valid_d = 1'b0;
        if (fill) valid_d = 1'b1;
        // On the fill edge valid is still low, so the fill itself counts as a hit.
        ok_d = slot_req & addr_match & (valid_q | fill);
        if (clr) begin
            valid_d = 1'b0;
            ok_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

    assign ok   = ok_q;
    assign data = data_q;

endmodule

// File: rtl/jt1943_rom_arb.sv
// ROM read arbiter: shares one SDRAM read channel among SLOTS requesters,
// each with a one-word cache.
// Ports:
//   clk, rst          : game clock, synchronous active-high reset
//   downloading       : ROM download in progress, aborts and blocks reads
//   slot_req/addr     : per-slot level request and relative word address
//   slot_ok/data      : per-slot registered valid flag and cached word
//   mem_req/addr      : SDRAM read request (held until mem_rdy), absolute address
//   mem_rdy/data      : SDRAM one-cycle ready pulse with data
module jt1943_rom_arb
    import jt1943_arb_pkg::*;
#(
    parameter int                    SLOTS       = 4,
    parameter int                    AW          = AW_DEF,
    parameter int                    DW          = DW_DEF,
    parameter logic [SLOTS*AW-1:0]   SLOT_OFFSET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_data,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_rdy,
    input  logic [DW-1:0]       mem_data
);

    arb_state_t    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    ptr_q, ptr_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic [SLOTS-1:0] hit, pending, load, fill;
    logic [AW-1:0]    abs_addr [SLOTS];
    rr_pick_t         pick;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign abs_addr[i] = slot_addr[i*AW +: AW] + SLOT_OFFSET[i*AW +: AW];
        assign pending[i]  = slot_req[i] & ~hit[i] &
                             ~((state_q == ARB_WAIT) && (grant_q == 3'(i)));

        jt1943_arb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clr       (downloading),
            .load      (load[i]),
            .fill      (fill[i]),
            .fill_data (mem_data),
            .slot_req  (slot_req[i]),
            .addr_in   (slot_addr[i*AW +: AW]),
            .hit       (hit[i]),
            .ok        (slot_ok[i]),
            .data      (slot_data[i*DW +: DW])
        );
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        load       = '0;
        fill       = '0;
        pick       = rr_pick(8'(pending), ptr_q, SLOTS);
        if (downloading) begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    mem_req_d = 1'b0;
                    if (pick.found) begin
                        grant_d   = pick.idx;
                        mem_req_d = 1'b1;
                        state_d   = ARB_WAIT;
                        for (int i = 0; i < SLOTS; i++) begin
                            if (pick.idx == 3'(i)) begin
                                mem_addr_d = abs_addr[i];
                                load[i]    = 1'b1;
                            end
                        end
                    end
                end
                ARB_WAIT: begin
                    if (mem_rdy) begin
                        mem_req_d = 1'b0;
                        ptr_d     = grant_q;
                        state_d   = ARB_IDLE;
                        for (int i = 0; i < SLOTS; i++) begin
                            if (grant_q == 3'(i)) fill[i] = 1'b1;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= 3'(SLOTS - 1);
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: doc/jt1943_rom_arb.md
Name: jt1943_rom_arb

Overview:
- Shares the single SDRAM read channel among several ROM requesters in the 1943 game core: main CPU, sound CPU, character, scroll and object graphics.
- Keeps one cached 32-bit word and address per requester. Repeated reads of the same address are answered without an SDRAM access.
- On a miss, grants the SDRAM channel round-robin and holds the request until the SDRAM controller returns data.
- Sits between the game sub-blocks and the SDRAM controller. Runs on the game clock.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, address width, in SDRAM words.
- DW, 32, data width of one SDRAM read.
- SLOT_OFFSET, {SLOTS*AW{1'b0}}, packed per-slot base offsets. Slot i uses bits [i*AW +: AW].

Ports:
- clk  in  1  game clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- downloading  in  1  ROM download in progress; aborts and blocks all reads.
- slot_req  in  SLOTS  per-slot read request, level.
- slot_addr  in  SLOTS*AW  per-slot word address, relative to the slot's region.
- slot_ok  out  SLOTS  slot_data for that slot is valid for the current slot_addr.
- slot_data  out  SLOTS*DW  per-slot cached data word.
- mem_req  out  1  SDRAM read request, held high until mem_rdy.
- mem_addr  out  AW  absolute SDRAM address = slot_addr + SLOT_OFFSET of the granted slot.
- mem_rdy  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  DW  SDRAM read data.

Behaviour:
- Reset values:
  - state IDLE, mem_req 0, mem_addr 0.
  - slot_ok all 0, slot_data all 0.
  - per-slot valid 0 and cached address 0.
  - round-robin pointer = SLOTS-1, so slot 0 is searched first.
- Hit and pending:
  - hit[i] = valid[i] & (cached_addr[i] == slot_addr[i]).
  - pending[i] = slot_req[i] & ~hit[i] & ~(state==WAIT & grant==i).
- slot_ok[i] is registered.
  - Each edge: slot_ok[i] <= slot_req[i] & hit[i].
  - Latency from a stable request on a hit: 1 cycle.
  - slot_ok falls one cycle after slot_req falls or slot_addr changes.
- Sum slot_addr + SLOT_OFFSET is AW bits and wraps modulo 2^AW. No overflow flag.
- FSM, 2 states:
  - IDLE:
    - If any pending, pick the first pending slot scanning ptr+1, ptr+2, … modulo SLOTS.
    - Register grant <= g.
    - mem_addr <= slot_addr[g] + offset[g].
    - cached_addr[g] <= slot_addr[g]; valid[g] <= 0.
    - mem_req <= 1; go to WAIT.
    - Otherwise stay; mem_req 0.
  - WAIT:
    - mem_req and mem_addr are held.
    - On mem_rdy=1: slot_data[grant] <= mem_data; valid[grant] <= 1; mem_req <= 0; ptr <= grant; go to IDLE.
    - slot_ok[grant] rises on that same edge if slot_req[grant] is still high and slot_addr[grant] == cached_addr[grant].
    - Otherwise slot_ok[grant] stays low.
- Back-to-back requests: at least one IDLE cycle between two mem_req assertions. A new grant cannot occur on the mem_rdy edge.
- Address change during WAIT:
  - Returned data is stored against the captured address. The slot's slot_ok stays 0.
  - The slot becomes pending again and is re-granted under normal round-robin.
- slot_req dropped during WAIT: the access completes and data is still cached. No cancellation.
- mem_rdy in IDLE is ignored.
- downloading=1, and likewise rst=1, in any state, on the next edge:
  - state IDLE, mem_req 0.
  - all valid 0, all slot_ok 0.
  - slot_data is kept unless rst.
  - While downloading=1 no grants are issued and mem_rdy is ignored.
- Slot fairness: each continuously missing slot is granted within SLOTS accesses.

Decomposition:
- Package jt1943_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_WAIT};
  - localparams for default AW/DW;
  - function rr_pick(pending, ptr) returning the index and a found flag.
- Sub-module jt1943_arb_slot, instantiated SLOTS times:
  - holds cached_addr, valid, data and the slot_ok register;
  - computes hit;
  - has load and clear strobes from the arbiter FSM.

Test Plan:
- Reset: drive rst for 2 cycles with slot_req=4'hF → mem_req=0, slot_ok=0, slot_data=0 throughout and on the cycle after release.
- Single miss, SLOT_OFFSET slot1=22'h10000:
  - Stimulus: slot_req[1]=1, slot_addr[1]=22'h00123; mem_rdy pulses 5 cycles after mem_req with 32'hDEADBEEF.
  - Required: mem_req=1 and mem_addr=22'h10123 one cycle later; slot_ok[1]=1 on the mem_rdy edge; slot_data[1]=32'hDEADBEEF; mem_req=0 next cycle.
- Hit: hold slot1 at the same address for 20 cycles after the fill → slot_ok[1] stays 1, mem_req stays 0. Drop slot_req[1] → slot_ok[1]=0 one cycle later.
- Round-robin: after reset, all four slots miss simultaneously and the responder answers each request in 3 cycles → grant order 0,1,2,3; each mem_req separated by 1 IDLE cycle.
- Address change in WAIT: slot0 requests 22'h0040, then switches to 22'h0041 before mem_rdy → slot_ok[0] stays 0; a second mem_req with mem_addr=22'h0041 follows; slot_ok[0]=1 after its mem_rdy.
- Download abort: assert downloading during WAIT → next edge mem_req=0 and slot_ok=0; a late mem_rdy is ignored; no mem_req while downloading=1; after release, previously valid slots re-fetch.
